nn_core_driver: RTL and testbench

Initiator side of the ap_ctrl_hs block-level handshake used by the network top level. Accepts 32-bit input samples on a valid/ready stream and issues one core transaction per sample: asserts `core_ap_start` with `core_input_V`/`core_input_V_ap_vld`, then captures the 16-bit `layer7_out_0_V` result when its `ap_vld` strobe fires. Results are buffered in a small FIFO and presented on an output valid/ready stream. Sits between the sample source (DMA or host bridge) and the inference core; it is also the standard bench driver for that core.

---
 rtl/nn_core_driver.sv | 162 ++++++++++++++++
 tb/tb_nn_core_driver.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_core_driver.sv
`timescale 1ns/1ps
// nn_core_driver: ap_ctrl_hs initiator. Issues one core transaction per input
// sample and queues the core results in a small FIFO for the output stream.
module nn_core_driver #(
    parameter int unsigned IN_W      = 32,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned RES_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             core_ap_start,
    input  logic             core_ap_ready,
    input  logic             core_ap_done,
    input  logic             core_ap_idle,
    output logic [IN_W-1:0]  core_input_V,
    output logic             core_input_V_ap_vld,
    input  logic [OUT_W-1:0] core_out_V,
    input  logic             core_out_V_ap_vld,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             timeout_err,
    output logic [15:0]      sample_count
);
    localparam int unsigned PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RES_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    input_q, input_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               got_q, got_d;
    logic               err_q, err_d;
    logic               alive_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [15:0]        count_q, count_d;
    logic [OUT_W-1:0]   mem_q [RES_DEPTH];
    logic               push, pop;
    logic               idle_unused;

    // Core idle is informational only; the handshake relies on ready/done.
    assign idle_unused = core_ap_idle;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            input_q <= '0;
            tmo_q   <= '0;
            got_q   <= 1'b0;
            err_q   <= 1'b0;
            alive_q <= 1'b0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            input_q <= input_d;
            tmo_q   <= tmo_d;
            got_q   <= got_d;
            err_q   <= err_d;
            alive_q <= 1'b1;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem_q[wr_q] <= core_out_V;
        end
    end

    // A completing done wins over the timeout; only the first result per
    // transaction is pushed (got_q remembers it across WAIT cycles).
    always_comb begin
        state_d = state_q;
        input_d = input_q;
        tmo_d   = tmo_q;
        got_d   = got_q;
        err_d   = err_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (s_valid && s_ready) begin
                    input_d = s_data;
                    tmo_d   = '0;
                    got_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (core_ap_ready && core_ap_done) begin
                    push    = core_out_V_ap_vld;
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (core_ap_ready) begin
                        push    = core_out_V_ap_vld;
                        got_d   = core_out_V_ap_vld;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (core_ap_done) begin
                    push    = core_out_V_ap_vld && !got_q;
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    push  = core_out_V_ap_vld && !got_q;
                    got_d = got_q || core_out_V_ap_vld;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // alive_q keeps s_ready low for the first cycle after reset.
    always_comb begin
        s_ready             = alive_q && (state_q == S_IDLE) && (cnt_q != FIFO_FULL);
        core_ap_start       = (state_q == S_ISSUE);
        core_input_V_ap_vld = (state_q == S_ISSUE);
        core_input_V        = input_q;
        m_valid             = (cnt_q != '0);
        m_data              = m_valid ? mem_q[rd_q] : '0;
        busy                = (state_q != S_IDLE) || m_valid;
        timeout_err         = err_q;
        sample_count        = count_q;
    end

    always_comb begin
        pop     = m_valid && m_ready;
        wr_d    = push ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = pop ? rd_q + PTR_W'(1) : rd_q;
        cnt_d   = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        count_d = push ? count_q + 16'd1 : count_q;
    end
endmodule

// File: tb/tb_nn_core_driver.sv
`timescale 1ns/1ps
// Directed bench for nn_core_driver with a small configurable core responder.
module tb_nn_core_driver;
    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        core_ap_start, core_ap_ready, core_ap_done, core_ap_idle;
    logic [31:0] core_input_V;
    logic        core_input_V_ap_vld;
    logic [15:0] core_out_V;
    logic        core_out_V_ap_vld;
    logic [15:0] m_data;
    logic        m_valid, m_ready;
    logic        busy, timeout_err;
    logic [15:0] sample_count;

    int n_pass  = 0;
    int n_total = 0;

    // 0 manual, 1 fixed latency, 2 zero latency, 3 never ready
    int          mode = 0;
    int          lat  = 1;
    logic        man_rdy = 1'b0, man_done = 1'b0, man_ovld = 1'b0;
    logic [15:0] man_out = '0;
    logic        mdl_rdy = 1'b0, mdl_done = 1'b0, mdl_ovld = 1'b0;
    logic [15:0] mdl_out = '0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] held = '0;

    assign core_ap_ready     = (mode == 0) ? man_rdy  : mdl_rdy;
    assign core_ap_done      = (mode == 0) ? man_done : mdl_done;
    assign core_out_V_ap_vld = (mode == 0) ? man_ovld : mdl_ovld;
    assign core_out_V        = (mode == 0) ? man_out  : mdl_out;
    assign core_ap_idle      = !core_ap_start;

    nn_core_driver #(
        .IN_W(32), .OUT_W(16), .RES_DEPTH(4), .TIMEOUT(1023)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .core_ap_start(core_ap_start), .core_ap_ready(core_ap_ready),
        .core_ap_done(core_ap_done), .core_ap_idle(core_ap_idle),
        .core_input_V(core_input_V), .core_input_V_ap_vld(core_input_V_ap_vld),
        .core_out_V(core_out_V), .core_out_V_ap_vld(core_out_V_ap_vld),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .timeout_err(timeout_err), .sample_count(sample_count)
    );

    always #5 ap_clk = ~ap_clk;

    // Core responder: result = low half of the sample + 0x0100.
    always @(negedge ap_clk) begin
        mdl_rdy = 1'b0; mdl_done = 1'b0; mdl_ovld = 1'b0; mdl_out = '0;
        if (mode == 1 || mode == 2) begin
            if (pend) begin
                if (cnt == 0) begin
                    mdl_ovld = 1'b1; mdl_done = 1'b1;
                    mdl_out = held[15:0] + 16'h0100;
                    pend = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end else if (core_ap_start === 1'b1) begin
                mdl_rdy = 1'b1;
                held = core_input_V;
                if (mode == 2) begin
                    mdl_ovld = 1'b1; mdl_done = 1'b1;
                    mdl_out = core_input_V[15:0] + 16'h0100;
                end else begin
                    pend = 1'b1; cnt = lat;
                end
            end
        end else begin
            pend = 1'b0;
        end
    end

    task automatic tick;
        @(negedge ap_clk);
    endtask

    task automatic do_reset;
        ap_rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; mode = 0;
        man_rdy = 1'b0; man_done = 1'b0; man_ovld = 1'b0; man_out = '0;
        tick();
        ap_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic [69:0] snap;
        int w;
        ap_rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        tick(); tick(); tick();
        ap_rst = 1'b0;
        snap = {s_ready, core_ap_start, core_input_V_ap_vld, core_input_V, m_valid,
                m_data, busy, timeout_err, sample_count};
        n_total++;
        if (snap !== '0) $display("FAIL reset_outputs: got %h expected 0", snap);
        else n_pass++;
        w = 0;
        while (s_ready !== 1'b1 && w < 5) begin tick(); w++; end
        n_total++;
        if (s_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", s_ready);
        else n_pass++;
    endtask

    task automatic test_basic;
        int starts;
        logic mv_early;
        do_reset();
        s_data = 32'h0000_1234; s_valid = 1'b1;
        n_total++;
        if (s_ready !== 1'b1) $display("FAIL basic_s_ready: got %b expected 1", s_ready);
        else n_pass++;
        tick();
        s_valid = 1'b0;
        n_total++;
        if ({core_ap_start, core_input_V_ap_vld, core_input_V} !== {2'b11, 32'h0000_1234})
            $display("FAIL basic_issue: got start=%b vld=%b in=%h expected 1 1 00001234",
                     core_ap_start, core_input_V_ap_vld, core_input_V);
        else n_pass++;
        starts = 1;
        man_rdy = 1'b1;
        tick();
        man_rdy = 1'b0;
        n_total++;
        if ({core_ap_start, s_ready, busy} !== 3'b001)
            $display("FAIL basic_wait: got start=%b s_ready=%b busy=%b expected 0 0 1",
                     core_ap_start, s_ready, busy);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (core_ap_start === 1'b1) starts++;
        end
        mv_early = m_valid;
        man_ovld = 1'b1; man_done = 1'b1; man_out = 16'h0ABC;
        tick();
        man_ovld = 1'b0; man_done = 1'b0; man_out = '0;
        n_total++;
        if (starts != 1) $display("FAIL basic_start_cycles: got %0d expected 1", starts);
        else n_pass++;
        n_total++;
        if ({mv_early, m_valid, m_data} !== {2'b01, 16'h0ABC})
            $display("FAIL basic_result: got early=%b m_valid=%b m_data=%h expected 0 1 0abc",
                     mv_early, m_valid, m_data);
        else n_pass++;
        n_total++;
        if (sample_count !== 16'd1) $display("FAIL basic_count: got %h expected 0001", sample_count);
        else n_pass++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        n_total++;
        if ({m_valid, busy} !== 2'b00)
            $display("FAIL basic_drain: got m_valid=%b busy=%b expected 0 0", m_valid, busy);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [31:0] din [6];
        logic [15:0] exp [6];
        int w, rx, nsent;
        logic acc;
        din = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030,
                32'h0000_0040, 32'h0000_0050, 32'h0000_0060};
        exp = '{16'h0110, 16'h0120, 16'h0130, 16'h0140, 16'h0150, 16'h0160};
        do_reset();
        mode = 1; lat = 1;
        for (int i = 0; i < 4; i++) begin
            s_data = din[i]; s_valid = 1'b1;
            w = 0;
            while (s_ready !== 1'b1 && w < 50) begin tick(); w++; end
            n_total++;
            if (s_ready !== 1'b1) $display("FAIL bp_accept_%0d: got s_ready=0 expected 1", i);
            else n_pass++;
            tick();
            s_valid = 1'b0;
        end
        for (int k = 0; k < 10; k++) tick();
        n_total++;
        if ({s_ready, m_valid, m_data, sample_count} !== {2'b01, 16'h0110, 16'd4})
            $display("FAIL bp_full: got s_ready=%b m_valid=%b m_data=%h count=%h expected 0 1 0110 0004",
                     s_ready, m_valid, m_data, sample_count);
        else n_pass++;
        s_data = din[4]; s_valid = 1'b1;
        tick(); tick(); tick();
        n_total++;
        if ({s_ready, core_ap_start} !== 2'b00)
            $display("FAIL bp_stall: got s_ready=%b start=%b expected 0 0", s_ready, core_ap_start);
        else n_pass++;
        m_ready = 1'b1;
        rx = 0; nsent = 4; w = 0;
        while (rx < 6 && w < 200) begin
            if (m_valid === 1'b1) begin
                n_total++;
                if (m_data !== exp[rx]) $display("FAIL bp_order_%0d: got %h expected %h", rx, m_data, exp[rx]);
                else n_pass++;
                rx++;
            end
            acc = s_valid && s_ready;
            tick();
            w++;
            if (acc) begin
                nsent++;
                if (nsent < 6) s_data = din[nsent];
                else s_valid = 1'b0;
            end
        end
        s_valid = 1'b0; m_ready = 1'b0;
        n_total++;
        if (rx != 6) $display("FAIL bp_drain_count: got %0d expected 6", rx);
        else n_pass++;
        n_total++;
        if ({m_valid, sample_count} !== {1'b0, 16'd6})
            $display("FAIL bp_total: got m_valid=%b count=%h expected 0 0006", m_valid, sample_count);
        else n_pass++;
    endtask

    task automatic test_zero_latency;
        logic [31:0] din [4];
        logic [15:0] exp [4];
        int t [4];
        int tacc, rx, sent;
        logic acc, mv_e1;
        din = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
        exp = '{16'h0101, 16'h0102, 16'h0103, 16'h0104};
        do_reset();
        mode = 2;
        s_data = 32'h0000_0042; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        mv_e1 = m_valid;
        n_total++;
        if ({core_ap_start, mv_e1} !== 2'b10)
            $display("FAIL zl_issue: got start=%b m_valid=%b expected 1 0", core_ap_start, mv_e1);
        else n_pass++;
        tick();
        n_total++;
        if ({m_valid, m_data, s_ready, core_ap_start} !== {1'b1, 16'h0142, 2'b10})
            $display("FAIL zl_result: got m_valid=%b m_data=%h s_ready=%b start=%b expected 1 0142 1 0",
                     m_valid, m_data, s_ready, core_ap_start);
        else n_pass++;
        m_ready = 1'b1;
        tick();
        rx = 0; sent = 0; tacc = -100;
        s_data = din[0]; s_valid = 1'b1;
        for (int j = 0; j < 60 && rx < 4; j++) begin
            if (m_valid === 1'b1) begin
                n_total++;
                if (m_data !== exp[rx]) $display("FAIL zl_b2b_data_%0d: got %h expected %h", rx, m_data, exp[rx]);
                else n_pass++;
                t[rx] = j;
                rx++;
            end
            acc = s_valid && s_ready;
            if (acc && sent == 0) tacc = j;
            tick();
            if (acc) begin
                sent++;
                if (sent < 4) s_data = din[sent];
                else s_valid = 1'b0;
            end
        end
        s_valid = 1'b0; m_ready = 1'b0;
        n_total++;
        if (rx != 4) $display("FAIL zl_b2b_count: got %0d expected 4", rx);
        else n_pass++;
        if (rx == 4) begin
            n_total++;
            if (t[0] - tacc != 2) $display("FAIL zl_latency: got %0d expected 2", t[0] - tacc);
            else n_pass++;
            for (int i = 1; i < 4; i++) begin
                n_total++;
                if (t[i] - t[i-1] != 2) $display("FAIL zl_spacing_%0d: got %0d expected 2", i, t[i] - t[i-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout;
        int starts;
        do_reset();
        mode = 3;
        s_data = 32'hDEAD_BEEF; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        n_total++;
        if ({core_ap_start, timeout_err} !== 2'b10)
            $display("FAIL to_start: got start=%b err=%b expected 1 0", core_ap_start, timeout_err);
        else n_pass++;
        starts = 0;
        for (int w = 0; w < 1100 && core_ap_start === 1'b1; w++) begin
            starts++;
            tick();
        end
        n_total++;
        if (starts != 1023) $display("FAIL to_issue_cycles: got %0d expected 1023", starts);
        else n_pass++;
        n_total++;
        if ({timeout_err, core_input_V_ap_vld, s_ready, m_valid, sample_count} !== {4'b1010, 16'd0})
            $display("FAIL to_abort: got err=%b vld=%b s_ready=%b m_valid=%b count=%h expected 1 0 1 0 0000",
                     timeout_err, core_input_V_ap_vld, s_ready, m_valid, sample_count);
        else n_pass++;
        tick(); tick();
        n_total++;
        if ({timeout_err, busy} !== 2'b10)
            $display("FAIL to_sticky: got err=%b busy=%b expected 1 0", timeout_err, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait;
        logic [69:0] snap;
        do_reset();
        mode = 1; lat = 1;
        for (int i = 0; i < 2; i++) begin
            s_data = 32'h0000_0007 + i; s_valid = 1'b1;
            for (int w = 0; w < 50 && s_ready !== 1'b1; w++) tick();
            tick();
            s_valid = 1'b0;
            for (int k = 0; k < 6; k++) tick();
        end
        n_total++;
        if ({m_valid, sample_count} !== {1'b1, 16'd2})
            $display("FAIL rst_pre_queue: got m_valid=%b count=%h expected 1 0002", m_valid, sample_count);
        else n_pass++;
        mode = 0;
        s_data = 32'h0000_0009; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        man_rdy = 1'b1;
        tick();
        man_rdy = 1'b0;
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        snap = {s_ready, core_ap_start, core_input_V_ap_vld, core_input_V, m_valid,
                m_data, busy, timeout_err, sample_count};
        n_total++;
        if (snap !== '0) $display("FAIL rst_mid_outputs: got %h expected 0", snap);
        else n_pass++;
        man_ovld = 1'b1; man_done = 1'b1; man_out = 16'hBEEF;
        tick();
        man_ovld = 1'b0; man_done = 1'b0; man_out = '0;
        tick();
        n_total++;
        if ({m_valid, busy, sample_count} !== {2'b00, 16'd0})
            $display("FAIL rst_late_vld: got m_valid=%b busy=%b count=%h expected 0 0 0000",
                     m_valid, busy, sample_count);
        else n_pass++;
    endtask

    task automatic test_spurious_and_wrap;
        do_reset();
        s_data = 32'h0000_00AA; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        man_rdy = 1'b1;
        tick();
        man_rdy = 1'b0;
        man_ovld = 1'b1; man_out = 16'h1111;
        tick();
        man_out = 16'h2222;
        tick();
        n_total++;
        if ({m_valid, m_data, sample_count} !== {1'b1, 16'h1111, 16'd1})
            $display("FAIL sp_first_vld: got m_valid=%b m_data=%h count=%h expected 1 1111 0001",
                     m_valid, m_data, sample_count);
        else n_pass++;
        man_ovld = 1'b0; man_out = '0; man_done = 1'b1;
        tick();
        man_done = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        n_total++;
        if ({m_valid, s_ready, sample_count} !== {2'b01, 16'd1})
            $display("FAIL sp_single_push: got m_valid=%b s_ready=%b count=%h expected 0 1 0001",
                     m_valid, s_ready, sample_count);
        else n_pass++;
        s_data = 32'h0000_00BB; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        man_rdy = 1'b1;
        tick();
        man_rdy = 1'b0; man_done = 1'b1;
        tick();
        man_done = 1'b0;
        n_total++;
        if ({m_valid, s_ready, busy, sample_count} !== {3'b010, 16'd1})
            $display("FAIL sp_done_no_vld: got m_valid=%b s_ready=%b busy=%b count=%h expected 0 1 0 0001",
                     m_valid, s_ready, busy, sample_count);
        else n_pass++;
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        mode = 2;
        s_data = 32'h0000_0055; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        n_total++;
        if ({m_valid, m_data, sample_count} !== {1'b1, 16'h0155, 16'h0000})
            $display("FAIL wrap_count: got m_valid=%b m_data=%h count=%h expected 1 0155 0000",
                     m_valid, m_data, sample_count);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        @(negedge ap_clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_latency();
        test_timeout();
        test_reset_mid_wait();
        test_spurious_and_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
